pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) writeback pipeline register.
// The skid entry absorbs one accepted input while the head is stalled, so
// in_ready can come straight from a flop without combinational feedback from
// out_ready. Register-file forwarding from both held entries is built only
// when PIPE_STAGE_FWD_EN is defined; otherwise the forwarding outputs are
// tied to zero and no comparators exist.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  input  logic [DEST_W-1:0] fwd_src_a,
  input  logic [DEST_W-1:0] fwd_src_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b
);

  logic              main_valid;
  logic              skid_valid;
  logic              in_ready_q;
  logic              main_rw;
  logic              skid_rw;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [DEST_W-1:0] main_dest;
  logic [DEST_W-1:0] skid_dest;

  logic              accept;
  logic              main_load;
  logic              skid_load;
  logic              in_rw_clean;
  logic              main_valid_nxt;
  logic              skid_valid_nxt;

  // Handshake decode and next valid state; flush overrides everything.
  always_comb begin
    accept         = in_valid && in_ready_q && !flush;
    main_load      = !main_valid || out_ready;
    skid_load      = accept && main_valid && !out_ready;
    in_rw_clean    = in_reg_write && (in_dest != '0);
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (main_load) begin
      // Skid (older) drains first; while skid is full in_ready is low, so
      // accept and skid_valid never coincide here.
      main_valid_nxt = skid_valid || accept;
      skid_valid_nxt = 1'b0;
    end else if (skid_load) begin
      skid_valid_nxt = 1'b1;
    end
  end

  // Control state: valid bits and the registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready_q <= !skid_valid_nxt;
    end
  end

  // Payload registers; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    if (main_load) begin
      if (skid_valid) begin
        main_rw   <= skid_rw;
        main_data <= skid_data;
        main_dest <= skid_dest;
      end else begin
        main_rw   <= in_rw_clean;
        main_data <= in_data;
        main_dest <= in_dest;
      end
    end
    if (skid_load) begin
      skid_rw   <= in_rw_clean;
      skid_data <= in_data;
      skid_dest <= in_dest;
    end
  end

  // Head outputs are masked by valid so an empty stage presents all zeros.
  always_comb begin
    in_ready      = in_ready_q;
    out_valid     = main_valid;
    out_reg_write = main_valid && main_rw;
    out_data      = main_valid ? main_data : '0;
    out_dest      = main_valid ? main_dest : '0;
  end

`ifdef PIPE_STAGE_FWD_EN
  logic main_hit_a;
  logic main_hit_b;
  logic skid_hit_a;
  logic skid_hit_b;

  // Forwarding match; the skid entry is younger and therefore wins.
  always_comb begin
    main_hit_a = main_valid && main_rw && (main_dest == fwd_src_a) && (fwd_src_a != '0);
    main_hit_b = main_valid && main_rw && (main_dest == fwd_src_b) && (fwd_src_b != '0);
    skid_hit_a = skid_valid && skid_rw && (skid_dest == fwd_src_a) && (fwd_src_a != '0);
    skid_hit_b = skid_valid && skid_rw && (skid_dest == fwd_src_b) && (fwd_src_b != '0);
    fwd_hit_a  = main_hit_a || skid_hit_a;
    fwd_hit_b  = main_hit_b || skid_hit_b;
    fwd_data_a = skid_hit_a ? skid_data : (main_hit_a ? main_data : '0);
    fwd_data_b = skid_hit_b ? skid_data : (main_hit_b ? main_data : '0);
  end
`else
  logic unused_fwd_src;

  // Forwarding disabled: ports remain, outputs are constant zero.
  always_comb begin
    unused_fwd_src = ^{fwd_src_a, fwd_src_b};
    fwd_hit_a      = 1'b0;
    fwd_hit_b      = 1'b0;
    fwd_data_a     = '0;
    fwd_data_b     = '0;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// two-deep FIFO model of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_reg_write = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_dest = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_reg_write;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_dest;
  logic [AW-1:0] fwd_src_a = '0;
  logic [AW-1:0] fwd_src_b = '0;
  logic          fwd_hit_a;
  logic          fwd_hit_b;
  logic [DW-1:0] fwd_data_a;
  logic [DW-1:0] fwd_data_b;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_stage_reg #(.DATA_W(DW), .DEST_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_data(out_data), .out_dest(out_dest),
    .fwd_src_a(fwd_src_a), .fwd_src_b(fwd_src_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two entries, oldest first.
  typedef struct packed {
    logic          rw;
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit   acc;
    bit   pop;
    ent_t e;
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.rw   = in_reg_write && (in_dest != 0);
        e.data = in_data;
        e.dest = in_dest;
        q.push_back(e);
      end
    end
  end

  // Youngest matching entry with a real register write supplies the data.
  function automatic void fwd_exp(input logic [AW-1:0] src, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (FWD) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].rw && (q[i].dest == src) && (src != 0)) begin
          hit = 1'b1;
          d   = q[i].data;
        end
      end
    end
  endfunction

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : compare
    logic          eh_a, eh_b;
    logic [DW-1:0] ed_a, ed_b;
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_reg_write", 64'(out_reg_write), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_dest", 64'(out_dest), 64'd0);
      check("rst_fwd_hit_a", 64'(fwd_hit_a), 64'd0);
      check("rst_fwd_hit_b", 64'(fwd_hit_b), 64'd0);
    end else begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        check("out_reg_write", 64'(out_reg_write), 64'(q[0].rw));
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_dest", 64'(out_dest), 64'(q[0].dest));
      end
      fwd_exp(fwd_src_a, eh_a, ed_a);
      fwd_exp(fwd_src_b, eh_b, ed_b);
      check("fwd_hit_a", 64'(fwd_hit_a), 64'(eh_a));
      check("fwd_data_a", 64'(fwd_data_a), 64'(ed_a));
      check("fwd_hit_b", 64'(fwd_hit_b), 64'(eh_b));
      check("fwd_data_b", 64'(fwd_data_b), 64'(ed_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [DW-1:0] d, input logic [AW-1:0] a);
    in_valid     = v;
    in_reg_write = rw;
    in_data      = d;
    in_dest      = a;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    step();

    // Single transfer, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h12345678, 5'd7);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'h12345678);
    check("single_dest", 64'(out_dest), 64'd7);
    check("single_rw", 64'(out_reg_write), 64'd1);
    step();
    check("single_drained", 64'(out_valid), 64'd0);

    // Backpressure: A then B held, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h1, 5'd1);
    step();
    drive(1'b1, 1'b1, 32'h2, 5'd2);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_stable", 64'(out_data), 64'h1);
    step();
    check("bp_head_still_A", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    step();
    check("bp_B_valid", 64'(out_valid), 64'd1);
    check("bp_B_data", 64'(out_data), 64'h2);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Forwarding priority, then flush with a simultaneous input
    out_ready = 1'b0;
    fwd_src_a = 5'd3;
    fwd_src_b = 5'd5;
    drive(1'b1, 1'b1, 32'hAA, 5'd3);
    step();
    drive(1'b1, 1'b1, 32'hBB, 5'd3);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("fwd_prio_hit_a", 64'(fwd_hit_a), FWD ? 64'd1 : 64'd0);
    check("fwd_prio_data_a", 64'(fwd_data_a), FWD ? 64'hBB : 64'd0);
    check("fwd_miss_b", 64'(fwd_hit_b), 64'd0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 32'h55, 5'd9);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    check("flush_input_dropped", 64'(out_valid), 64'd0);

    // Write to register 0 is neutralised
    fwd_src_a = 5'd0;
    drive(1'b1, 1'b1, 32'h77, 5'd0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("r0_valid", 64'(out_valid), 64'd1);
    check("r0_rw", 64'(out_reg_write), 64'd0);
    check("r0_fwd_hit_a", 64'(fwd_hit_a), 64'd0);
    out_ready = 1'b1;
    step();

    // Asynchronous reset mid-cycle with both entries valid
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hC1, 5'd4);
    step();
    drive(1'b1, 1'b1, 32'hC2, 5'd6);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("arst_pre_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid_drop", 64'(out_valid), 64'd0);
    check("arst_out_data_zero", 64'(out_data), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("arst_in_ready_after", 64'(in_ready), 64'd1);
    check("arst_out_valid_after", 64'(out_valid), 64'd0);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      in_reg_write = ($urandom_range(0, 3) != 0);
      in_data      = $urandom;
      in_dest      = AW'($urandom_range(0, 3));
      fwd_src_a    = AW'($urandom_range(0, 3));
      fwd_src_b    = AW'($urandom_range(0, 3));
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
